serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial adder that produces a WIDTH-bit sum and carry-out from two parallel operands. Each clock it resolves one bit, LSB first, through a single full-adder cell built from two half-adder stages plus a carry flip-flop. It sits directly downstream of the combinational half-adder cell. It turns that cell into a sequential multi-bit datapath with a start/done handshake for the arithmetic test benches and later ALU work.

## Interface
- WIDTH, 8: operand and sum width in bits; legal range WIDTH ≥ 2.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; synchronous and active-low.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  registered result, held between operations.
- carry_out  output  1  registered carry out of bit WIDTH-1, held with sum.
- sub  input  1  subtract select; port exists only with SERIAL_ADDER_SUB_EN.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE**
  - When start=1, latch a into shift register A and b into shift register B.
  - Clear the carry flip-flop, clear the bit counter, and go to RUN.
  - When start=0, stay in IDLE.
- **RUN**, once per cycle:
  - Bit i = A[0] ^ B[0] ^ c.
  - Next c = (A[0]&B[0]) | (c&(A[0]^B[0])).
  - Shift A and B right by one.
  - Shift bit i into the MSB of the partial-sum register.
  - Increment the counter.
  - After the WIDTH-th bit, copy the partial sum to sum and the final c to carry_out, then go to DONE.
- **DONE**: assert done for one cycle, then go to IDLE unconditionally.
- start is ignored in RUN and DONE. It is not queued.
- Operands are captured at start, so a and b may change freely afterwards.
- sum and carry_out change only on the completion edge. During a following RUN they keep showing the previous result.
- The result is exact modulo 2^WIDTH; carry_out is the (WIDTH+1)-th bit.
- The counter width is $clog2(WIDTH). The completion compare is against WIDTH-1.

## Timing
- Reset values (rst_n=0 at a rising edge): state=IDLE, busy=0, done=0, sum=0, carry_out=0, internal registers 0.
- Reset takes priority over start and aborts any RUN in progress with no result update.
- Start accepted at edge 0:
  - busy=1 after edge 0.
  - Bits are processed on edges 1..WIDTH.
  - After edge WIDTH: done=1, busy=0, sum and carry_out valid.
  - After edge WIDTH+1: done=0, state is IDLE.
- Latency from start edge to done is WIDTH cycles.
- Minimum start-to-start spacing is WIDTH+2 cycles.
- If start is held high continuously, the block re-accepts on the first IDLE edge after DONE.

## Configuration
- Macro SERIAL_ADDER_SUB_EN.
- **Defined:**
  - The sub input port exists and is latched with the operands.
  - When sub=1, B is latched as ~b and the carry flip-flop initialises to 1, giving a − b modulo 2^WIDTH.
  - carry_out=1 means no borrow, i.e. a ≥ b unsigned.
  - When sub=0, behaviour is identical to the undefined case.
- **Undefined:** no sub port; addition only; the carry flip-flop always initialises to 0.

## Structure
- Package serial_adder_pkg holds:
  - the state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the default-width constant SERIAL_ADDER_WIDTH=8.
- Sub-module full_adder_cell:
  - Inputs a, b, cin; outputs sum, cout.
  - Built from two half-adder stages plus an OR.
  - Instantiated once for the per-bit datapath.
- The top level holds the FSM, counter, shift registers and result registers.

## Test plan
- a=8'h05, b=8'h03, start pulse → done exactly 8 cycles later, sum=8'h08, carry_out=0; busy high for 8 cycles.
- a=8'hFF, b=8'h01 → sum=8'h00, carry_out=1; a=8'hFF, b=8'hFF → sum=8'hFE, carry_out=1.
- Start 8'h10+8'h20, then pulse start with 8'hAA+8'h55 at cycle 3 of RUN → single done, sum=8'h30; second request ignored; previous sum held during RUN.
- rst_n=0 at cycle 4 of RUN → next cycle: IDLE, busy=0, done=0, sum=0, carry_out=0; no done pulse follows.
- Start held high for 30 cycles with 8'h01+8'h01 → done pulses every 10 cycles, each with sum=8'h02.
- SERIAL_ADDER_SUB_EN defined, sub=1:
  - 8'h07−8'h05 → sum=8'h02, carry_out=1.
  - 8'h05−8'h07 → sum=8'hFE, carry_out=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state encoding and default width for the bit-serial adder
package serial_adder_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam int SERIAL_ADDER_WIDTH = 8;
endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// full_adder_cell: one-bit full adder built from two cascaded half adders and an OR
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic s1, c1, c2;
    assign s1   = a ^ b;
    assign c1   = a & b;
    assign sum  = s1 ^ cin;
    assign c2   = s1 & cin;
    assign cout = c1 | c2;
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder with start/done handshake; SERIAL_ADDER_SUB_EN adds the sub port
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);
    localparam int CW = $clog2(WIDTH);
    state_t state, state_n;
    logic [WIDTH-1:0] a_sr, b_sr, psum;
    logic [CW-1:0] cnt;
    logic c, fa_s, fa_c, last, sub_sel;
`ifdef SERIAL_ADDER_SUB_EN
    assign sub_sel = sub;
`else
    assign sub_sel = 1'b0;
`endif
    assign last = cnt == CW'(WIDTH - 1);
    full_adder_cell u_fa (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .cin (c),
        .sum (fa_s),
        .cout(fa_c)
    );
    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end
    // next state and handshake outputs
    always_comb begin
        state_n = state;
        state_n = (state == IDLE) ? (start ? RUN : IDLE) :
                  (state == RUN)  ? (last ? DONE : RUN) : IDLE;
        busy = state == RUN;
        done = state == DONE;
    end
    // operand capture, serial datapath and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr      <= '0;
            b_sr      <= '0;
            psum      <= '0;
            cnt       <= '0;
            c         <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else if (state == IDLE && start) begin
            a_sr <= a;
            b_sr <= sub_sel ? ~b : b;
            c    <= sub_sel;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            c    <= fa_c;
            psum <= {fa_s, psum[WIDTH-1:1]};
            cnt  <= cnt + CW'(1);
            if (last) begin
                sum       <= {fa_s, psum[WIDTH-1:1]};
                carry_out <= fa_c;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: vector table, directed corner sequences and random ops against an arithmetic model
module tb_serial_adder;
    localparam int W = 8;
    logic clk = 0, rst_n = 0, start = 0;
    logic [W-1:0] a = '0, b = '0;
    logic busy, done, carry_out;
    logic [W-1:0] sum;
`ifdef SERIAL_ADDER_SUB_EN
    logic sub = 0;
`endif
    int total = 0, bad = 0;

    typedef struct {
        logic [W-1:0] a, b;
        logic         s;
        logic [W-1:0] es;
        logic         ec;
    } vec_t;

    serial_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef SERIAL_ADDER_SUB_EN
        .sub      (sub),
`endif
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .carry_out(carry_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vs,
                      input logic [W-1:0] es, input logic ec, input string name);
        int n, bc;
        @(negedge clk);
        a = va; b = vb; start = 1;
`ifdef SERIAL_ADDER_SUB_EN
        sub = vs;
`endif
        @(posedge clk);
        @(negedge clk);
        start = 0; a = ~va; b = ~vb;
        n = 0; bc = busy ? 1 : 0;
        while (n < 4 * W) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) break;
            if (busy) bc++;
        end
        chk({name, " latency"}, n, W);
        chk({name, " busy_cycles"}, bc, W);
        chk({name, " busy_at_done"}, busy, 0);
        chk({name, " sum"}, sum, es);
        chk({name, " carry"}, carry_out, ec);
        @(posedge clk);
        @(negedge clk);
        chk({name, " done_pulse"}, done, 0);
    endtask

    initial begin
        vec_t tbl[5];
        logic [W-1:0] ra, rb, prev;
        logic [W:0] m;
        logic rs, ok, ok2;
        int dn, last_t, t;
        tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tbl[2] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1};
        tbl[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        tbl[4] = '{8'h3C, 8'h41, 1'b0, 8'h7D, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst sum", sum, 0);
        chk("rst carry", carry_out, 0);
        rst_n = 1;

        for (int i = 0; i < 5; i++)
            op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].es, tbl[i].ec, $sformatf("vec%0d", i));

        // second start during RUN is ignored; previous result held while running
        prev = sum;
        @(negedge clk);
        a = 8'h10; b = 8'h20; start = 1;
        @(posedge clk);
        @(negedge clk);
        start = 0;
        ok = 1; dn = 0; ok2 = 1;
        for (int i = 0; i < 3 * W; i++) begin
            if (i == 2) begin a = 8'hAA; b = 8'h55; start = 1; end
            else start = 0;
            @(posedge clk);
            @(negedge clk);
            if (busy && sum !== prev) ok = 0;
            if (done) begin dn++; if (sum !== 8'h30) ok2 = 0; end
        end
        start = 0;
        chk("ign held_sum", ok, 1);
        chk("ign done_count", dn, 1);
        chk("ign sum", ok2, 1);
        chk("ign final_sum", sum, 8'h30);

        // reset mid-run aborts without result update
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; start = 1;
        @(posedge clk);
        @(negedge clk);
        start = 0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 0;
        @(posedge clk);
        @(negedge clk);
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort sum", sum, 0);
        chk("abort carry", carry_out, 0);
        rst_n = 1;
        dn = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) dn++;
        end
        chk("abort no_done", dn, 0);

        // start held high: back-to-back operations every W+2 cycles
        a = 8'h01; b = 8'h01; start = 1;
        dn = 0; ok = 1; ok2 = 1; last_t = -1;
        for (t = 0; t < 30; t++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                dn++;
                if (sum !== 8'h02) ok = 0;
                if (last_t >= 0 && t - last_t != W + 2) ok2 = 0;
                last_t = t;
            end
        end
        start = 0;
        chk("held done_count", dn, 3);
        chk("held sum", ok, 1);
        chk("held spacing", ok2, 1);
        repeat (W + 3) @(posedge clk);

`ifdef SERIAL_ADDER_SUB_EN
        op(8'h07, 8'h05, 1'b1, 8'h02, 1'b1, "sub7m5");
        op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, "sub5m7");
`endif

        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom);
`endif
            if (rs) m = {ra >= rb ? 1'b1 : 1'b0, W'(ra - rb)};
            else    m = (W + 1)'(ra) + (W + 1)'(rb);
            op(ra, rb, rs, m[W-1:0], m[W], $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
